// File: rtl/motion_pkg.sv
// Shared motion-control definitions for the axis step generators and the
// upstream speed planner.
//   motion_state_e : step generator sequencing states
//   max_rate()     : highest step rate that still leaves a full low phase
//                    equal to the pulse width between steps
package motion_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    PULSE,
    FINISH
  } motion_state_e;

  function automatic int unsigned max_rate(input int unsigned clk_freq,
                                           input int unsigned pulse_width);
    return clk_freq / (2 * pulse_width);
  endfunction

endpackage

// File: rtl/step_rate_nco.sv
// Phase-accumulator step-rate oscillator. The rate is clamped so that
// overflows are always at least 2*PULSE_WIDTH cycles apart, which keeps a
// step pulse from ever overlapping the next overflow.
// Ports:
//   clk, reset : clock, async active-low reset
//   clear      : zero the accumulator (move start)
//   en         : integrate this cycle
//   speed      : requested rate in steps/s
//   tick       : overflow this cycle (combinational strobe)
module step_rate_nco
  import motion_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned PULSE_WIDTH = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] speed,
  output logic        tick
);

  localparam logic [32:0] MODULUS  = 33'(CLK_FREQ);
  localparam logic [31:0] MAX_RATE = max_rate(CLK_FREQ, PULSE_WIDTH);

  logic [32:0] acc;
  logic [32:0] sum;
  logic [31:0] speed_c;

  always_comb begin
    speed_c = (speed > MAX_RATE) ? MAX_RATE : speed;
    sum     = acc + {1'b0, speed_c};
    tick    = en && (sum >= MODULUS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= tick ? (sum - MODULUS) : sum;
    end
  end

endmodule

// File: rtl/step_pulse_generator.sv
// Single-axis step/direction generator. Takes a signed step count and a
// live speed, drives step/direction/enable, and reports completion.
// Ports:
//   clk, reset          : clock, async active-low reset
//   start               : one-cycle move request (IDLE only)
//   num                 : signed step count, sign selects direction
//   speed               : steps/s, sampled every RUN cycle
//   abort               : stop at the next step boundary
//   limit_neg/limit_pos : endstops, honoured only in the direction of travel
//   stepper_step        : step pulse, PULSE_WIDTH cycles high
//   stepper_direction   : 1 = positive
//   stepper_enable      : driver enable request, cleared only by reset
//   busy, done, aborted : move status; aborted is valid with done
//   steps_done          : pulses issued in the current or last move
//
// state  | meaning
// IDLE   | waiting for start
// SETUP  | direction settling before the first step
// RUN    | integrating rate, waiting for an NCO overflow
// PULSE  | step held high; stop requests are latched, not acted on
// FINISH | one cycle to raise done and drop busy
//
// DIR_SETUP and PULSE_WIDTH must both be at least 1.
module step_pulse_generator
  import motion_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned PULSE_WIDTH = 50,
  parameter int unsigned DIR_SETUP   = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] num,
  input  logic [31:0] speed,
  input  logic        abort,
  input  logic        limit_neg,
  input  logic        limit_pos,
  output logic        stepper_step,
  output logic        stepper_direction,
  output logic        stepper_enable,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [31:0] steps_done
);

  localparam int unsigned TIMER_MAX = (DIR_SETUP > PULSE_WIDTH) ? DIR_SETUP : PULSE_WIDTH;
  localparam int TW = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TW-1:0] SETUP_LOAD = TW'(DIR_SETUP - 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_WIDTH - 1);

  motion_state_e state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [31:0]   remaining, remaining_n;
  logic [31:0]   steps_done_n;
  logic          step_n, dir_n, enable_n, busy_n, done_n, aborted_n;
  logic          nco_clear, nco_en, tick;
  logic          stop;

  step_rate_nco #(
    .CLK_FREQ    (CLK_FREQ),
    .PULSE_WIDTH (PULSE_WIDTH)
  ) u_nco (
    .clk   (clk),
    .reset (reset),
    .clear (nco_clear),
    .en    (nco_en),
    .speed (speed),
    .tick  (tick)
  );

  // A limit switch only matters when we are travelling towards it.
  assign stop = abort | (limit_neg & ~stepper_direction) | (limit_pos & stepper_direction);

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    remaining_n  = remaining;
    steps_done_n = steps_done;
    step_n       = stepper_step;
    dir_n        = stepper_direction;
    enable_n     = stepper_enable;
    busy_n       = busy;
    done_n       = 1'b0;
    aborted_n    = aborted;
    nco_clear    = 1'b0;
    nco_en       = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          remaining_n  = num[31] ? (~num + 32'd1) : num;
          dir_n        = ~num[31];
          steps_done_n = '0;
          aborted_n    = 1'b0;
          nco_clear    = 1'b1;
          busy_n       = 1'b1;
          enable_n     = 1'b1;
          timer_n      = SETUP_LOAD;
          state_n      = (num == '0) ? FINISH : SETUP;
        end
      end
      SETUP: begin
        if (stop) begin
          aborted_n = 1'b1;
          state_n   = FINISH;
        end else if (timer == '0) begin
          state_n = RUN;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      RUN: begin
        nco_en = 1'b1;
        if (stop) begin
          aborted_n = 1'b1;
          state_n   = FINISH;
        end else if (tick) begin
          step_n       = 1'b1;
          remaining_n  = remaining - 32'd1;
          steps_done_n = steps_done + 32'd1;
          timer_n      = PULSE_LOAD;
          state_n      = PULSE;
        end
      end
      PULSE: begin
        // Keep integrating so the step spacing is unaffected by the pulse.
        nco_en = 1'b1;
        if (stop) aborted_n = 1'b1;
        if (timer == '0) begin
          step_n  = 1'b0;
          state_n = ((remaining == '0) || aborted || stop) ? FINISH : RUN;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      FINISH: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      timer             <= '0;
      remaining         <= '0;
      steps_done        <= '0;
      stepper_step      <= 1'b0;
      stepper_direction <= 1'b0;
      stepper_enable    <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      aborted           <= 1'b0;
    end else begin
      state             <= state_n;
      timer             <= timer_n;
      remaining         <= remaining_n;
      steps_done        <= steps_done_n;
      stepper_step      <= step_n;
      stepper_direction <= dir_n;
      stepper_enable    <= enable_n;
      busy              <= busy_n;
      done              <= done_n;
      aborted           <= aborted_n;
    end
  end

endmodule

// File: tb/tb_step_pulse_generator.sv
module tb_step_pulse_generator;

  localparam int unsigned F    = 1000;
  localparam int unsigned PW   = 2;
  localparam int unsigned DS   = 3;
  localparam int unsigned MAXR = F / (2 * PW);

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] num;
  logic [31:0] speed;
  logic        abort;
  logic        limit_neg;
  logic        limit_pos;
  logic        stepper_step;
  logic        stepper_direction;
  logic        stepper_enable;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [31:0] steps_done;

  step_pulse_generator #(
    .CLK_FREQ    (F),
    .PULSE_WIDTH (PW),
    .DIR_SETUP   (DS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .num               (num),
    .speed             (speed),
    .abort             (abort),
    .limit_neg         (limit_neg),
    .limit_pos         (limit_pos),
    .stepper_step      (stepper_step),
    .stepper_direction (stepper_direction),
    .stepper_enable    (stepper_enable),
    .busy              (busy),
    .done              (done),
    .aborted           (aborted),
    .steps_done        (steps_done)
  );

  typedef struct {
    int unsigned t;
    bit          ab;
    int unsigned steps;
    bit          dir;
  } done_rec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  int unsigned exp_edges[$];
  done_rec_t   exp_done[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Constant speed s: the accumulator integrates every cycle from RUN entry,
  // so the k-th overflow lands ceil(k*F/s) cycles after entering RUN.
  function automatic int unsigned edge_time(input int unsigned t0, input int unsigned s,
                                            input int unsigned k);
    int unsigned sc = (s > MAXR) ? MAXR : s;
    return t0 + DS + 1 + (k * F + sc - 1) / sc;
  endfunction

  // Monitor / scoreboard
  bit          prev_step = 1'b0;
  int unsigned hi_len    = 0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_step = 1'b0;
      hi_len    = 0;
    end else begin
      if (stepper_step && !prev_step) begin
        if (exp_edges.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL edge_unexpected at cycle %0d", cyc);
        end else begin
          chk("edge_time", cyc, exp_edges.pop_front());
        end
      end
      if (stepper_step) hi_len++;
      if (!stepper_step && prev_step) begin
        chk("pulse_width", hi_len, PW);
        hi_len = 0;
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected at cycle %0d", cyc);
        end else begin
          done_rec_t r;
          r = exp_done.pop_front();
          chk("done_time", cyc, r.t);
          chk("aborted", aborted, r.ab);
          chk("steps_done", steps_done, r.steps);
          chk("direction", stepper_direction, r.dir);
          chk("busy_at_done", busy, 0);
          chk("enable_at_done", stepper_enable, 1);
          chk("edges_left", exp_edges.size(), 0);
        end
      end
      prev_step = stepper_step;
    end
  end

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic start_move(input logic [31:0] n, input int unsigned s, input int unsigned nexp,
                            input bit push_done, input bit ab, output int unsigned t0);
    int unsigned last;
    @(negedge clk);
    num   = n;
    speed = s;
    start = 1'b1;
    t0    = cyc;
    for (int unsigned k = 1; k <= nexp; k++) exp_edges.push_back(edge_time(t0, s, k));
    if (push_done) begin
      last = (nexp == 0) ? t0 + 2 : edge_time(t0, s, nexp) + PW + 1;
      exp_done.push_back('{t: last, ab: ab, steps: nexp, dir: ~n[31]});
    end
    @(negedge clk);
    start = 1'b0;
    num   = $urandom;
    chk("busy_rise", busy, 1);
    chk("dir_latched", stepper_direction, {31'd0, ~n[31]});
    chk("enable_set", stepper_enable, 1);
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (exp_done.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", exp_done.size(), 0);
    if (exp_done.size() != 0) begin
      exp_done.delete();
      exp_edges.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int unsigned t0;
    int unsigned ta;
    reset     = 1'b0;
    start     = 1'b0;
    num       = '0;
    speed     = '0;
    abort     = 1'b0;
    limit_neg = 1'b0;
    limit_pos = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_step", stepper_step, 0);
    chk("rst_dir", stepper_direction, 0);
    chk("rst_enable", stepper_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_steps_done", steps_done, 0);
    reset = 1'b1;
    @(negedge clk);

    // Positive move; a second start mid-move must be ignored.
    start_move(32'd5, 100, 5, 1'b1, 1'b0, t0);
    wait_until(edge_time(t0, 100, 2) + 3);
    num   = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200);

    // Negative move.
    start_move(32'hFFFF_FFFD, 100, 3, 1'b1, 1'b0, t0);
    wait_done(200);

    // Zero-length move.
    start_move(32'd0, 100, 0, 1'b1, 1'b0, t0);
    wait_done(20);

    // Negative limit during pulse 4 of a negative move.
    start_move(-32'sd100, 100, 4, 1'b1, 1'b1, t0);
    wait_until(edge_time(t0, 100, 4) + 1);
    limit_neg = 1'b1;
    wait_done(200);
    limit_neg = 1'b0;

    // Opposite-direction limit is ignored for the whole move.
    start_move(-32'sd100, 100, 100, 1'b1, 1'b0, t0);
    limit_pos = 1'b1;
    wait_done(1500);
    limit_pos = 1'b0;

    // Speed above the clamp.
    start_move(32'd10, 900, 10, 1'b1, 1'b0, t0);
    wait_done(200);

    // Stall at speed 0 after pulse 3, released only by abort.
    start_move(32'd10, 900, 3, 1'b0, 1'b0, t0);
    wait_until(edge_time(t0, 900, 3));
    speed = '0;
    repeat (20) @(negedge clk);
    abort = 1'b1;
    ta    = cyc;
    exp_done.push_back('{t: ta + 2, ab: 1'b1, steps: 3, dir: 1'b1});
    @(negedge clk);
    abort = 1'b0;
    wait_done(50);

    // Random moves, some aborted during a pulse.
    for (int i = 0; i < 12; i++) begin
      int          nn;
      int unsigned mag;
      int unsigned s;
      int unsigned k;
      bit          do_stop;
      nn      = int'($urandom_range(12)) - 6;
      mag     = (nn < 0) ? -nn : nn;
      s       = $urandom_range(1200, 40);
      do_stop = (mag >= 2) && ($urandom_range(2) == 0);
      k       = do_stop ? $urandom_range(mag - 1, 1) : mag;
      start_move(32'(nn), s, k, 1'b1, do_stop, t0);
      if (do_stop) begin
        wait_until(edge_time(t0, s, k) + 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
      wait_done(500);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    // Asynchronous reset during the high phase of pulse 2.
    start_move(32'd4, 100, 2, 1'b0, 1'b0, t0);
    wait_until(edge_time(t0, 100, 2));
    @(posedge clk);
    #2;
    chk("step_before_reset", stepper_step, 1);
    reset = 1'b0;
    #1;
    chk("async_rst_step", stepper_step, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_enable", stepper_enable, 0);
    exp_edges.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    chk("rst_steps_done2", steps_done, 0);
    reset = 1'b1;
    @(negedge clk);
    start_move(32'd2, 100, 2, 1'b1, 1'b0, t0);
    wait_done(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_pulse_generator.md
# step_pulse_generator

Single-axis step/direction generator placed directly downstream of `jerk_acc_speed`, one instance per motor (a, b, z, e). It takes a signed microstep count and a live speed in microsteps/s, which the upstream speed planner may change every cycle, and drives the stepper driver's step, direction and enable pins. Step rate comes from a phase-accumulator NCO, so no divider is needed. It reports completion to the motion sequencer and stops early on a limit switch or abort.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz; also the NCO modulus.
- `PULSE_WIDTH`, default 50: step high time in clk cycles.
- `DIR_SETUP`, default 25: cycles from direction change to first step.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: one-cycle move request; sampled only in IDLE.
- `num` input, 32 bits: signed two's-complement microstep count; sign gives direction.
- `speed` input, 32 bits: microsteps/s from upstream; sampled every RUN cycle.
- `abort` input, 1 bit: stop the move at the next step boundary.
- `limit_neg` input, 1 bit: endstop in the negative direction, active-high.
- `limit_pos` input, 1 bit: endstop in the positive direction, active-high.
- `stepper_step` output, 1 bit: step pulse.
- `stepper_direction` output, 1 bit: 1 = positive.
- `stepper_enable` output, 1 bit: active-high enable request; the top level inverts it for the driver.
- `busy` output, 1 bit: move in progress.
- `done` output, 1 bit: one-cycle completion strobe.
- `aborted` output, 1 bit: valid with `done`; move ended early.
- `steps_done` output, 32 bits: unsigned count of pulses issued in the current or last move.

## Operation
- States: IDLE, SETUP, RUN, PULSE, FINISH.
- **IDLE, `start`=1:**
  - Latch |num| into `remaining` and num[31] inverted into `stepper_direction`.
  - Clear `steps_done`, `aborted` and the accumulator; set `busy` and `stepper_enable`.
  - If num==0, go to FINISH. Otherwise go to SETUP.
- **SETUP:** count DIR_SETUP cycles, then go to RUN.
- **RUN:**
  - Each cycle, `speed_c` = min(speed, MAX_RATE), where MAX_RATE = CLK_FREQ/(2·PULSE_WIDTH) (localparam).
  - If acc + speed_c ≥ CLK_FREQ: acc ← acc + speed_c − CLK_FREQ, drive `stepper_step`=1, decrement `remaining`, increment `steps_done`, go to PULSE.
  - Otherwise acc ← acc + speed_c.
  - Accumulator is 33 bits, unsigned compare.
- **PULSE:**
  - Hold step high for PULSE_WIDTH cycles; the accumulator keeps integrating.
  - The clamp guarantees no overflow can be pending when the pulse ends.
  - After the pulse, go to FINISH if `remaining`==0 or a stop condition is latched; otherwise go to RUN.
- **Stop conditions:** `abort`, or (`limit_neg` & direction==0), or (`limit_pos` & direction==1).
  - Evaluated in SETUP and RUN; a condition occurring in PULSE is latched.
  - Never truncates a pulse in progress.
  - Sets `aborted`.
  - A limit in the opposite direction is ignored.
- **FINISH:** `done`=1 for one cycle, `busy`←0, go to IDLE. `stepper_enable` stays 1; it is cleared only by reset.
- speed==0 in RUN: the block stalls with no steps; only abort/limit exits.
- `start` while busy: ignored. `num` is not re-sampled after start.

## Timing
- Reset values: step 0, direction 0, enable 0, busy 0, done 0, aborted 0, steps_done 0, state IDLE, acc 0.
- Reset is effective asynchronously mid-pulse.
- All outputs are registered.
- `busy` rises the cycle after `start`; direction is valid the same cycle.
- The first RUN cycle is DIR_SETUP+1 cycles after `start`.
- Constant speed s ≤ MAX_RATE: rising edges are CLK_FREQ/s cycles apart on average, jitter ≤ 1 cycle. The first edge comes ceil(CLK_FREQ/s) RUN cycles after entering RUN.
- `done` is asserted one cycle after the last pulse's falling edge.
- num==0: `done` is asserted 2 cycles after `start`.
- A limit rising during SETUP/RUN gives no further rising edge, and `done` follows within 2 cycles.

## Structure
- Package `motion_pkg`: state enum (IDLE, SETUP, RUN, PULSE, FINISH) and a shared helper for MAX_RATE. The same package serves all four axis instances and `jerk_acc_speed`.
- Sub-module `step_rate_nco`: accumulator, clamp and overflow strobe. Inputs are clk, reset, clear, en and speed; output is `tick`.
- The FSM and counters stay in the top module.

## Test plan
Benches use CLK_FREQ=1000, PULSE_WIDTH=2, DIR_SETUP=3.
- num=5, speed=100: 5 pulses, each 2 cycles high, rising edges 10 cycles apart; direction=1; `done` once, aborted=0, steps_done=5.
- num=0xFFFFFFFD (−3), speed=100: direction=0, 3 pulses, steps_done=3.
- num=0: no pulse; busy=1 for 1 cycle; `done` 2 cycles after start.
- num=−100, speed=100, limit_neg raised 1 cycle after the 4th rising edge: no 5th edge, `done` with aborted=1, steps_done=4. The same stimulus with limit_pos instead runs all 100 steps.
- num=10, speed=900: clamped to 250, rising edges every 4 cycles, 10 pulses. Dropping speed to 0 after pulse 3 stalls the move until abort; then done with aborted=1, steps_done=3.
- reset low during the high phase of pulse 2: step, busy and enable are 0 in the same cycle. After release, a new start with num=2 runs normally with steps_done=2.
